// File: rtl/timer_pkg.sv
// Shared constants for the timer count stage: width defaults,
// clock-select encodings and count direction.
package timer_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_DIV_W = 4;
  localparam int DEF_CKS_W = 2;

  // Clock select: one tick every 2^(cks+1) pclk.
  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  // Count direction as seen on the updown input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: free-running divider that produces a
// one-cycle tick whenever its low cks+1 bits are all ones.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CKS_W = DEF_CKS_W
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             en,
  input  logic             load,
  input  logic [CKS_W-1:0] cks,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] sel_mask;

  // Build the mask of the div_cnt bits that define the selected period
  // and flag the boundary where all of them are set.
  // NOTE: every output of a combinational block gets a value on every
  // path (defaults first) so no latch is inferred.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < DIV_W; i++) begin
      sel_mask[i] = (i <= int'(cks));
    end
    tick = en & ~load & ((div_cnt & sel_mask) == sel_mask);
  end

  // Divider: runs while counting is enabled, restarts from zero after a
  // load or while disabled; a cks change does not disturb it.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      div_cnt <= '0;
    end else if (!en || load) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Timer count stage: prescaled up/down counter with tdr reload.
// last_cnt trails cnt by one pclk so the compare stage sees a wrap as a
// one-cycle (last_cnt, cnt) pair; a load writes both so it never looks
// like a wrap.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W,
  parameter int CKS_W = DEF_CKS_W
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             en,
  input  logic             load,
  input  logic             updown,
  input  logic [CKS_W-1:0] cks,
  input  logic [CNT_W-1:0] tdr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] last_cnt,
  output logic             cnt_tick
);

  logic tick;

  timer_prescaler #(
    .DIV_W (DIV_W),
    .CKS_W (CKS_W)
  ) u_prescaler (
    .pclk     (pclk),
    .preset_n (preset_n),
    .en       (en),
    .load     (load),
    .cks      (cks),
    .tick     (tick)
  );

  // Count registers: load has priority, otherwise step on a tick in the
  // sampled direction; last_cnt follows cnt every cycle.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      cnt      <= '0;
      last_cnt <= '0;
      cnt_tick <= 1'b0;
    end else begin
      cnt_tick <= tick;
      if (load) begin
        cnt      <= tdr;
        last_cnt <= tdr;
      end else begin
        last_cnt <= cnt;
        if (tick) begin
          if (updown == DIR_DOWN) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: a cycle model pushes expected
// outputs into a scoreboard queue each time stimulus is applied; the
// entry is popped and compared after the clock edge.
module tb_timer_counter;
  import timer_pkg::*;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] last;
    logic       tick;
  } exp_t;

  logic       pclk;
  logic       preset_n;
  logic       en;
  logic       load;
  logic       updown;
  logic [1:0] cks;
  logic [7:0] tdr;
  logic [7:0] cnt;
  logic [7:0] last_cnt;
  logic       cnt_tick;

  exp_t       sb_q[$];

  // Reference model state
  logic [3:0] m_div;
  logic [7:0] m_cnt;
  logic [7:0] m_last;
  logic       m_tick;

  int n_vec;
  int n_err;
  int pair_seen;
  logic [7:0] pair_last;
  logic [7:0] pair_cnt;

  timer_counter dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .en       (en),
    .load     (load),
    .updown   (updown),
    .cks      (cks),
    .tdr      (tdr),
    .cnt      (cnt),
    .last_cnt (last_cnt),
    .cnt_tick (cnt_tick)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div  = '0;
    m_cnt  = '0;
    m_last = '0;
    m_tick = 1'b0;
  endtask

  // Advance the model one pclk using the inputs now applied, push the
  // expectation, clock the DUT and compare against the popped entry.
  task automatic step();
    logic [3:0] mask;
    logic       t;
    exp_t       e;
    mask = 4'((32'd1 << (int'(cks) + 1)) - 1);
    t = en && !load && ((m_div & mask) == mask);
    if (load) begin
      m_cnt  = tdr;
      m_last = tdr;
    end else begin
      m_last = m_cnt;
      if (t) m_cnt = updown ? m_cnt - 8'd1 : m_cnt + 8'd1;
    end
    m_div  = (!en || load) ? 4'd0 : m_div + 4'd1;
    m_tick = t;
    sb_q.push_back('{cnt: m_cnt, last: m_last, tick: m_tick});
    @(posedge pclk);
    #1;
    e = sb_q.pop_front();
    check("cnt", 32'(cnt), 32'(e.cnt));
    check("last_cnt", 32'(last_cnt), 32'(e.last));
    check("cnt_tick", 32'(cnt_tick), 32'(e.tick));
    if (last_cnt == pair_last && cnt == pair_cnt && last_cnt != cnt) pair_seen++;
  endtask

  // Step until cnt changes; n returns the number of pclk taken, or -1
  // if the bound expired.
  task automatic wait_change(input int max_cyc, output int n);
    logic [7:0] start;
    start = cnt;
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (cnt != start) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic watch_pair(input logic [7:0] l, input logic [7:0] c);
    pair_last = l;
    pair_cnt  = c;
    pair_seen = 0;
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;
    watch_pair(8'h00, 8'h00);
    preset_n = 1'b0;
    en = 1'b0; load = 1'b0; updown = DIR_UP; cks = CKS_DIV2; tdr = 8'h00;
    model_reset();
    #12;
    check("reset_cnt", 32'(cnt), 32'h0);
    check("reset_last", 32'(last_cnt), 32'h0);
    check("reset_tick", 32'(cnt_tick), 32'h0);
    preset_n = 1'b1;
    @(posedge pclk); #1;

    // Count up by 2 from reset
    en = 1'b1;
    wait_change(4, n);
    check("div2_first", 32'(n), 32'd2);
    check("div2_val1", 32'(cnt), 32'h01);
    wait_change(4, n);
    check("div2_space", 32'(n), 32'd2);
    check("div2_val2", 32'(cnt), 32'h02);
    for (int i = 0; i < 6; i++) step();

    // Load FE, count up by 4 through the FF->00 wrap
    watch_pair(8'hFF, 8'h00);
    load = 1'b1; tdr = 8'hFE;
    step();
    check("ld_fe", 32'(cnt), 32'hFE);
    load = 1'b0; cks = CKS_DIV4;
    wait_change(8, n);
    check("div4_space1", 32'(n), 32'd4);
    check("div4_ff", 32'(cnt), 32'hFF);
    wait_change(8, n);
    check("div4_space2", 32'(n), 32'd4);
    check("div4_wrap", 32'(cnt), 32'h00);
    for (int i = 0; i < 5; i++) step();
    check("up_wrap_pair_once", 32'(pair_seen), 32'd1);

    // Load 01, count down by 16 through the 00->FF wrap
    watch_pair(8'h00, 8'hFF);
    load = 1'b1; tdr = 8'h01; updown = DIR_DOWN; cks = CKS_DIV16;
    step();
    load = 1'b0;
    wait_change(20, n);
    check("div16_space1", 32'(n), 32'd16);
    check("div16_00", 32'(cnt), 32'h00);
    wait_change(20, n);
    check("div16_space2", 32'(n), 32'd16);
    check("div16_wrap", 32'(cnt), 32'hFF);
    for (int i = 0; i < 5; i++) step();
    check("dn_wrap_pair_once", 32'(pair_seen), 32'd1);

    // Load colliding with a due tick at FF
    watch_pair(8'hFF, 8'h00);
    updown = DIR_UP; cks = CKS_DIV2;
    load = 1'b1; tdr = 8'hFF;
    step();
    load = 1'b0;
    step();                      // divider now at the tick boundary
    load = 1'b1; tdr = 8'h00;
    step();
    check("ld_tick_cnt", 32'(cnt), 32'h00);
    check("ld_tick_last", 32'(last_cnt), 32'h00);
    check("ld_tick_notick", 32'(cnt_tick), 32'h0);
    load = 1'b0;
    wait_change(4, n);
    check("ld_div_cleared", 32'(n), 32'd2);
    check("ld_no_wrap_pair", 32'(pair_seen), 32'd0);

    // en dropped mid-period, re-enabled at divide-by-8
    step();
    en = 1'b0;
    begin
      logic [7:0] frozen;
      frozen = cnt;
      for (int i = 0; i < 10; i++) step();
      check("en0_frozen", 32'(cnt), 32'(frozen));
      check("en0_last_conv", 32'(last_cnt), 32'(frozen));
    end
    en = 1'b1; cks = CKS_DIV8;
    wait_change(12, n);
    check("reen_div8", 32'(n), 32'd8);

    // Asynchronous reset mid-count at 37
    load = 1'b1; tdr = 8'h37;
    step();
    load = 1'b0; cks = CKS_DIV16;
    step();
    step();
    check("pre_rst_37", 32'(cnt), 32'h37);
    #2;
    preset_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(cnt), 32'h0);
    check("async_rst_last", 32'(last_cnt), 32'h0);
    check("async_rst_tick", 32'(cnt_tick), 32'h0);
    model_reset();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
